// File: rtl/game_sequencer_if.sv
// Game controller bundle: datapath status in, frame timebase / game state / score out.
// The master modport is the game_sequencer side; the slave modport is the datapath side.
interface game_sequencer_if #(
   parameter int unsigned CntW = 5
) ();
   logic            start;
   logic [9:0]      doodle_y;
   logic            doodle_fall_direction;
   logic            collision;
   logic [CntW-1:0] fps_counter;
   logic            frame_tick;
   logic [1:0]      game_state;
   logic            game_rst;
   logic            scroll_start;
   logic            scroll_active;
   logic [15:0]     score;
   logic [15:0]     high_score;

   modport master (
      input  start, doodle_y, doodle_fall_direction, collision,
      output fps_counter, frame_tick, game_state, game_rst, scroll_start, scroll_active,
             score, high_score
   );

   modport slave (
      output start, doodle_y, doodle_fall_direction, collision,
      input  fps_counter, frame_tick, game_state, game_rst, scroll_start, scroll_active,
             score, high_score
   );
endinterface

// File: rtl/game_sequencer.sv
// Doodle Jump top-level controller: frame timebase, game FSM, scroll schedule and score.
// Define GAME_SEQUENCER_HIGH_SCORE_EN to keep a best-score register latched on GAME_OVER.
module game_sequencer #(
   parameter int unsigned FPS           = 60,
   parameter int unsigned CLK           = 50_000_000,
   parameter int unsigned SCROLL_LINE   = 300,
   parameter int unsigned FLOOR_Y       = 768,
   parameter int unsigned SCROLL_FRAMES = 16,
   parameter int unsigned DEATH_FRAMES  = 90
) (
   input logic               clk_i,
   input logic               rst_ni,
   game_sequencer_if.master  gs_io
);
   localparam int unsigned CntW = $clog2(CLK / FPS) + 1;
   localparam int unsigned ScW  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

   typedef enum logic [1:0] {
      StMenu     = 2'd0,
      StPlay     = 2'd1,
      StFalling  = 2'd2,
      StGameOver = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   fps_q;
   logic              start_q;
   logic [6:0]        death_cnt_q, death_cnt_d;
   logic [ScW-1:0]    scroll_cnt_q, scroll_cnt_d;
   logic              scroll_active_q, scroll_active_d;
   logic              scroll_start_q, scroll_start_d;
   logic              game_rst_q, game_rst_d;
   logic [15:0]       score_q, score_d;

   logic frame_tick, start_edge, death_hit, scroll_trig, dying_done;

   assign frame_tick  = &fps_q;
   assign start_edge  = gs_io.start & ~start_q;
   assign death_hit   = (state_q == StPlay) & frame_tick & gs_io.doodle_fall_direction &
                        (gs_io.doodle_y >= 10'(FLOOR_Y));
   assign scroll_trig = (state_q == StPlay) & frame_tick & gs_io.collision &
                        (gs_io.doodle_y < 10'(SCROLL_LINE)) & ~scroll_active_q;
   assign dying_done  = (state_q == StFalling) & frame_tick &
                        (death_cnt_q == 7'(DEATH_FRAMES - 1));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= StMenu;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StMenu:     if (start_edge) state_d = StPlay;
         StPlay:     if (death_hit)  state_d = StFalling;
         StFalling:  if (dying_done) state_d = StGameOver;
         StGameOver: if (start_edge) state_d = StMenu;
         default:    state_d = StMenu;
      endcase
   end

   // Death takes priority over a scroll trigger on the same tick and aborts any burst.
   always_comb begin
      death_cnt_d     = death_cnt_q;
      scroll_cnt_d    = scroll_cnt_q;
      scroll_active_d = scroll_active_q;
      scroll_start_d  = 1'b0;
      game_rst_d      = (state_q == StMenu) & start_edge;
      score_d         = score_q;
      if ((state_q == StMenu) && start_edge) begin
         score_d         = '0;
         scroll_active_d = 1'b0;
      end
      if (death_hit) begin
         scroll_active_d = 1'b0;
         death_cnt_d     = '0;
      end else if (scroll_trig) begin
         scroll_start_d  = 1'b1;
         scroll_active_d = 1'b1;
         scroll_cnt_d    = '0;
      end else if ((state_q == StPlay) && frame_tick && scroll_active_q) begin
         scroll_cnt_d = scroll_cnt_q + 1'b1;
         score_d      = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
         if (scroll_cnt_q == ScW'(SCROLL_FRAMES - 1)) scroll_active_d = 1'b0;
      end
      if ((state_q == StFalling) && frame_tick && !dying_done) begin
         death_cnt_d = death_cnt_q + 7'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         fps_q           <= '0;
         start_q         <= 1'b0;
         death_cnt_q     <= '0;
         scroll_cnt_q    <= '0;
         scroll_active_q <= 1'b0;
         scroll_start_q  <= 1'b0;
         game_rst_q      <= 1'b1;
         score_q         <= '0;
      end else begin
         fps_q           <= fps_q + 1'b1;
         start_q         <= gs_io.start;
         death_cnt_q     <= death_cnt_d;
         scroll_cnt_q    <= scroll_cnt_d;
         scroll_active_q <= scroll_active_d;
         scroll_start_q  <= scroll_start_d;
         game_rst_q      <= game_rst_d;
         score_q         <= score_d;
      end
   end

`ifdef GAME_SEQUENCER_HIGH_SCORE_EN
   logic [15:0] high_score_q, high_score_d;

   always_comb begin
      high_score_d = high_score_q;
      if (dying_done && (score_q > high_score_q)) high_score_d = score_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) high_score_q <= '0;
      else         high_score_q <= high_score_d;
   end

   assign gs_io.high_score = high_score_q;
`else
   assign gs_io.high_score = 16'd0;
`endif

   assign gs_io.fps_counter   = fps_q;
   assign gs_io.frame_tick    = frame_tick;
   assign gs_io.game_state    = state_q;
   assign gs_io.game_rst      = game_rst_q;
   assign gs_io.scroll_start  = scroll_start_q;
   assign gs_io.scroll_active = scroll_active_q;
   assign gs_io.score         = score_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer at CLK=1000, FPS=100 (32-cycle frame).
// A second instance with FLOOR_Y=200 lets death and scroll trigger coincide on one tick.
module tb_game_sequencer;
`ifdef GAME_SEQUENCER_HIGH_SCORE_EN
   localparam bit HsEn = 1'b1;
`else
   localparam bit HsEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [9:0] doodle_y = 10'd400;
   logic       fall = 1'b0;
   logic       col = 1'b0;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   game_sequencer_if #(.CntW(5)) m_if ();
   game_sequencer_if #(.CntW(5)) s_if ();

   assign m_if.start = start;
   assign m_if.doodle_y = doodle_y;
   assign m_if.doodle_fall_direction = fall;
   assign m_if.collision = col;
   assign s_if.start = start;
   assign s_if.doodle_y = doodle_y;
   assign s_if.doodle_fall_direction = fall;
   assign s_if.collision = col;

   game_sequencer #(.FPS(100), .CLK(1000)) u_dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .gs_io (m_if)
   );

   game_sequencer #(.FPS(100), .CLK(1000), .FLOOR_Y(200)) u_dut_low_floor (
      .clk_i (clk),
      .rst_ni(rst_n),
      .gs_io (s_if)
   );

   typedef struct {
      bit         st;
      bit         col;
      logic [9:0] y;
      bit         fall;
      int         frames;
      logic [1:0] e_state;
      bit         e_ss;
      bit         e_sa;
      logic [15:0] e_score;
      logic [15:0] e_hs;
   } vec_t;

   vec_t tbl[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Runs until the end of the next tick cycle; sample point is then fps_counter == 0.
   task automatic wait_tick();
      int g = 0;
      while (m_if.frame_tick !== 1'b1 && g < 40) begin
         cyc();
         g++;
      end
      if (g >= 40) begin
         checks++;
         errors++;
         $display("FAIL tick_timeout: got no tick expected one within 40 cycles");
      end
      cyc();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int g;
      // idle = no collision, mid-screen, rising
      tbl[0]  = '{0, 1, 10'd300, 0, 1,  2'd1, 0, 0, 16'd0,  16'd0};
      tbl[1]  = '{0, 1, 10'd250, 0, 1,  2'd1, 1, 1, 16'd0,  16'd0};
      tbl[2]  = '{0, 1, 10'd250, 0, 1,  2'd1, 0, 1, 16'd1,  16'd0};
      tbl[3]  = '{0, 0, 10'd400, 0, 14, 2'd1, 0, 1, 16'd15, 16'd0};
      tbl[4]  = '{0, 0, 10'd400, 0, 1,  2'd1, 0, 0, 16'd16, 16'd0};
      tbl[5]  = '{0, 0, 10'd768, 0, 1,  2'd1, 0, 0, 16'd16, 16'd0};
      tbl[6]  = '{0, 1, 10'd250, 0, 1,  2'd1, 1, 1, 16'd16, 16'd0};
      tbl[7]  = '{0, 0, 10'd400, 0, 15, 2'd1, 0, 1, 16'd31, 16'd0};
      tbl[8]  = '{0, 0, 10'd400, 0, 1,  2'd1, 0, 0, 16'd32, 16'd0};
      tbl[9]  = '{0, 0, 10'd768, 1, 1,  2'd2, 0, 0, 16'd32, 16'd0};
      tbl[10] = '{1, 0, 10'd400, 0, 89, 2'd2, 0, 0, 16'd32, 16'd0};
      tbl[11] = '{0, 0, 10'd400, 0, 1,  2'd3, 0, 0, 16'd32, 16'd32};
      tbl[12] = '{1, 0, 10'd400, 0, 1,  2'd0, 0, 0, 16'd32, 16'd32};
      tbl[13] = '{1, 0, 10'd400, 0, 1,  2'd1, 0, 0, 16'd0,  16'd32};
      tbl[14] = '{0, 1, 10'd250, 0, 1,  2'd1, 1, 1, 16'd0,  16'd32};
      tbl[15] = '{0, 0, 10'd400, 0, 16, 2'd1, 0, 0, 16'd16, 16'd32};
      tbl[16] = '{0, 0, 10'd768, 1, 1,  2'd2, 0, 0, 16'd16, 16'd32};
      tbl[17] = '{0, 0, 10'd400, 0, 90, 2'd3, 0, 0, 16'd16, 16'd32};

      // Reset
      rst_n = 1'b0;
      repeat (3) cyc();
      chk("rst_state", m_if.game_state, 0);
      chk("rst_fps", m_if.fps_counter, 0);
      chk("rst_tick", m_if.frame_tick, 0);
      chk("rst_score", m_if.score, 0);
      chk("rst_hs", m_if.high_score, 0);
      chk("rst_ss", m_if.scroll_start, 0);
      chk("rst_sa", m_if.scroll_active, 0);
      chk("rst_grst", m_if.game_rst, 1);
      rst_n = 1'b1;
      chk("grst_before_edge", m_if.game_rst, 1);
      cyc();
      chk("grst_after_edge", m_if.game_rst, 0);
      for (int i = 1; i < 32; i++) begin
         chk("fps_count", m_if.fps_counter, i);
         chk("tick_only_at_31", m_if.frame_tick, (i == 31) ? 1 : 0);
         cyc();
      end
      chk("fps_wrap", m_if.fps_counter, 0);
      chk("tick_after_wrap", m_if.frame_tick, 0);

      // Start pulse, then start held high in PLAY
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("start_state", m_if.game_state, 1);
      chk("start_grst", m_if.game_rst, 1);
      cyc();
      chk("grst_width", m_if.game_rst, 0);
      start = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         if (m_if.game_state !== 2'd1 || m_if.game_rst !== 1'b0) bad++;
      end
      chk("held_start_ignored", bad, 0);
      start = 1'b0;
      g = 0;
      while (m_if.fps_counter !== 5'd0 && g < 40) begin
         cyc();
         g++;
      end

      // Table: one row = inputs held for `frames` ticks, outputs checked after the last
      for (int r = 0; r < 18; r++) begin
         col = tbl[r].col;
         doodle_y = tbl[r].y;
         fall = tbl[r].fall;
         for (int f = 0; f < tbl[r].frames; f++) begin
            if (f == 0 && tbl[r].st) begin
               start = 1'b1;
               cyc();
               start = 1'b0;
            end
            wait_tick();
         end
         chk($sformatf("row%0d_state", r), m_if.game_state, tbl[r].e_state);
         chk($sformatf("row%0d_scroll_start", r), m_if.scroll_start, tbl[r].e_ss);
         chk($sformatf("row%0d_scroll_active", r), m_if.scroll_active, tbl[r].e_sa);
         chk($sformatf("row%0d_score", r), m_if.score, tbl[r].e_score);
         chk($sformatf("row%0d_high_score", r), m_if.high_score, HsEn ? tbl[r].e_hs : 16'd0);
         if (tbl[r].e_ss) begin
            chk($sformatf("row%0d_ss_at_fps0", r), m_if.fps_counter, 0);
            col = 1'b0;
            cyc();
            chk($sformatf("row%0d_ss_width", r), m_if.scroll_start, 0);
         end
      end
      col = 1'b0;
      doodle_y = 10'd400;
      fall = 1'b0;

      // Death and scroll trigger on the same tick (low-floor instance), then reset mid-scroll
      rst_n = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("sim_main_play", m_if.game_state, 1);
      chk("sim_low_play", s_if.game_state, 1);
      col = 1'b1;
      doodle_y = 10'd250;
      fall = 1'b1;
      wait_tick();
      col = 1'b0;
      doodle_y = 10'd400;
      fall = 1'b0;
      chk("sim_low_state", s_if.game_state, 2);
      chk("sim_low_ss", s_if.scroll_start, 0);
      chk("sim_low_sa", s_if.scroll_active, 0);
      chk("sim_main_ss", m_if.scroll_start, 1);
      chk("sim_main_sa", m_if.scroll_active, 1);
      repeat (5) cyc();
      rst_n = 1'b0;
      cyc();
      chk("midrst_sa", m_if.scroll_active, 0);
      chk("midrst_state", m_if.game_state, 0);
      chk("midrst_grst", m_if.game_rst, 1);
      chk("midrst_fps", m_if.fps_counter, 0);
      rst_n = 1'b1;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game controller for the Doodle Jump datapath. It owns the frame timebase (`fps_counter`), the global game state consumed by the doodle, platform and renderer blocks, and the camera-scroll schedule that drives the doodle's `move_collision` input. It also keeps score and high score, and issues a datapath clear pulse on every new game.

## Interface
Parameters:
- `FPS`, 60: frame rate used to size the timebase.
- `CLK`, 50_000_000: pixel/system clock frequency in Hz.
- `SCROLL_LINE`, 300: doodle_y below which a landing triggers a scroll.
- `FLOOR_Y`, 768: doodle_y at or beyond which the doodle is lost.
- `SCROLL_FRAMES`, 16: frames per scroll burst.
- `DEATH_FRAMES`, 90: frames spent in FALLING before GAME_OVER.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous, active-low reset (0 = reset).
- `start`  input  1  start button, level, already synchronised.
- `doodle_y`  input  10  doodle top edge from the doodle block.
- `doodle_fall_direction`  input  1  1 = doodle moving down.
- `collision`  input  1  doodle landed on a platform this frame.
- `fps_counter`  output  $clog2(CLK/FPS)+1  free-running frame timebase.
- `frame_tick`  output  1  `&fps_counter`, combinational.
- `game_state`  output  2  0 MENU, 1 PLAY, 2 FALLING, 3 GAME_OVER.
- `game_rst`  output  1  active-high datapath clear.
- `scroll_start`  output  1  one-cycle pulse to the doodle `move_collision`.
- `scroll_active`  output  1  scroll burst in progress.
- `score`  output  16  current score.
- `high_score`  output  16  best score since reset.

## Operation
- **Timebase:** `fps_counter` increments every cycle and wraps from all-ones to 0. `frame_tick` is 1 exactly when the counter is all-ones. Frame period is 2^W cycles.
- **Start detect:** `start` is registered into `start_q`. Edge = `start & ~start_q`, evaluated on any cycle.
- **State transitions:**
  - MENU → PLAY on a start edge. `game_rst` is 1 for exactly the following cycle. `score` clears to 0 on the same edge.
  - PLAY → FALLING on a frame_tick cycle with `doodle_fall_direction`=1 and `doodle_y >= FLOOR_Y` (unsigned 10-bit compare). An in-progress scroll is aborted and `scroll_active` goes to 0.
  - FALLING: a 7-bit `death_cnt` increments on each frame_tick. On the tick where `death_cnt == DEATH_FRAMES-1`, the state goes to GAME_OVER.
  - GAME_OVER → MENU on a start edge. Start edges in PLAY and FALLING are ignored.
- **Scroll scheduler (PLAY only):**
  - Trigger: a frame_tick cycle with `collision`=1, `doodle_y < SCROLL_LINE`, and `scroll_active`=0. Then `scroll_start`=1 for the next cycle only, `scroll_active`=1, and `scroll_cnt` is loaded with 0.
  - While active, each frame_tick increments `scroll_cnt` and `score` (+1, saturating at 16'hFFFF).
  - After SCROLL_FRAMES ticks, `scroll_active` returns to 0.
  - Collisions during an active burst are ignored; no queueing.
- **Simultaneous events:** when a death condition and a scroll trigger fall on the same tick, death wins and no `scroll_start` is issued.
- **Reset:** all state is cleared regardless of the current state. Reset values are:
  - `game_state`=0, `fps_counter`=0, `frame_tick`=0, `score`=0, `high_score`=0.
  - `scroll_start`=0, `scroll_active`=0, `game_rst`=1.
  - `game_rst` falls on the first edge with `rst`=1.

## Timing
- All outputs except `frame_tick` are registered and update on the clock edge ending the evaluating cycle.
- Latencies:
  - start edge → `game_state` change: 1 cycle.
  - start edge → `game_rst` pulse: 1 cycle (same edge as the state change).
  - Scroll trigger tick → `scroll_start`: 1 cycle, width exactly 1 cycle, coincident with `fps_counter`=0. The doodle samples it on the next tick.
  - Death tick → FALLING: 1 cycle.
- `scroll_active` spans SCROLL_FRAMES×2^W cycles ± 0.
- `score` changes only on tick edges.

## Configuration
- `GAME_SEQUENCER_HIGH_SCORE_EN` defined: on entry to GAME_OVER, `high_score` ← max(`high_score`, `score`), compared unsigned. The value is held across games and cleared only by `rst`.
- Not defined: `high_score` is constant 0 and no register is inferred.

## Test plan
All scenarios use CLK=1000, FPS=100, giving W=5 and a 32-cycle frame.

- **Reset:** hold `rst`=0 for 3 cycles, then release → all outputs at their reset values; `game_rst`=1 until the first edge after release; `fps_counter` wraps 31→0 with `frame_tick` high only at 31.
- **Start sequence:**
  - Pulse `start` in MENU → next cycle `game_state`=1, `game_rst`=1 for 1 cycle.
  - Hold `start` high for 100 cycles → no further transitions.
- **Scroll trigger:**
  - PLAY, `collision`=1, `doodle_y`=250 at a tick → `scroll_start`=1 for 1 cycle; `scroll_active`=1 for 16 frames (512 cycles); `score`=16.
  - A second collision during the burst → no second pulse.
  - `doodle_y`=300 at a tick → no trigger (boundary).
- **Death:**
  - PLAY, `doodle_y`=768, `doodle_fall_direction`=1 at a tick → FALLING; after 90 ticks → GAME_OVER.
  - Same `doodle_y` with `doodle_fall_direction`=0 → stays PLAY.
- **Simultaneous events:** `collision`=1, `doodle_y`=250, plus a death condition on the same tick → state FALLING, `scroll_start` stays 0. Separately, assert `rst`=0 mid-scroll → `scroll_active`=0 and `game_state`=0 the next cycle.
- **High score (macro defined):**
  - Game 1 score 32, game 2 score 16 → `high_score`=32 after each GAME_OVER.
  - Macro undefined → `high_score`=0 throughout.
